mem_host_responder: RTL and testbench
=====================================

# mem_host_responder

Cache-line memory responder that sits on the far side of the CPU's two host memory ports: instruction fetch (`Fe*_host`) and data memory (`Me*_host`). It accepts line-sized read and write requests from both ports and arbitrates between them round-robin. Each accepted request is served from an internal line array after a fixed latency, with completion signalled by `rd_valid`/`tx_done` pulses. It stands in for the off-chip memory controller in CPU-level simulation and FPGA bring-up.

## Interface
- `LINE_BITS`, 512, cache-line width in bits.
- `ADDR_BITS`, 32, byte-address width.
- `DEPTH_LINES`, 256, number of lines in the backing array (power of two).
- `LATENCY`, 4, cycles from accept to response (≥2).

Ports:
- `clk` in 1 — system clock.
- `rst_n` in 1 — one clock; reset is asynchronous and active-low.
- `FeDataOut_host` in LINE_BITS — fetch write data.
- `FeAddrOut_host` in ADDR_BITS — fetch byte address.
- `Feop_host` in 2 — fetch op: 00 idle, 01 read, 10 write, 11 reserved.
- `FeDataIn_host` out LINE_BITS — fetch read data.
- `Ferd_valid_host` out 1 — fetch read data valid, one-cycle pulse.
- `Fetx_done_host` out 1 — fetch transaction complete, one-cycle pulse.
- `MeDataOut_host`, `MeAddrOut_host`, `Meop_host` — inputs, same widths and meanings for the memory port.
- `MeDataIn_host`, `Merd_valid_host`, `Metx_done_host` — outputs, same widths and meanings for the memory port.

## Operation
- Line index is `addr[6 +: log2(DEPTH_LINES)]`. Address bits [5:0] and upper bits are ignored.
- Op 11 is treated as idle and never accepted.
- Requester holds op, addr and data stable until its done pulse, then drives op = 00 on the following cycle.
- State machine has three states:
  - IDLE: any port with a nonzero, non-reserved op requests. If one port requests, grant it. If both request, grant the port not granted last; the `last_grant` flop resets to Fe, so Me wins the first tie. On grant, latch port, op, line index and write data, load the counter with LATENCY−1, and go to BUSY.
  - BUSY: decrement the counter. When it reaches 0, drive the response and go to RECOVER.
    - Read: `DataIn` ← array[index], with `rd_valid` = 1 and `tx_done` = 1 on the granted port.
    - Write: array[index] ← latched data on this edge, `tx_done` = 1, `rd_valid` = 0.
  - RECOVER: one cycle with no sampling, so a still-held op is not reissued. Then go to IDLE.
- Non-granted port outputs stay 0. `DataIn` holds its last read value until the next read on that port.
- Input changes during BUSY are ignored; latched values are used.
- Write to line X followed by a read of X from either port returns the new data (single array, no bypass needed because writes commit before RECOVER).

## Timing
- Reset values: all `rd_valid`/`tx_done` = 0, both `DataIn` = 0, state IDLE, `last_grant` = Fe.
- Array contents are not reset.
- Accept on edge t ⇒ response outputs high for exactly the cycle after edge t+LATENCY. The next accept can occur no earlier than edge t+LATENCY+2.
- Back-to-back throughput: one transaction per LATENCY+2 cycles.
- Reset asserted while BUSY aborts the transaction: no response and no array write. All outputs are 0 asynchronously.
- Simultaneous requests alternate strictly. A port that keeps requesting waits at most one transaction.

## Structure
- `mem_host_pkg` holds:
  - `host_op_e` (IDLE/READ/WRITE/RSVD)
  - `resp_state_e` (IDLE/BUSY/RECOVER)
  - `LINE_BITS` and `ADDR_BITS` defaults
- Sub-module `mem_line_array`: single-port DEPTH_LINES × LINE_BITS array with synchronous write and combinational read. Instantiated once.

## Test plan
- Single read: after reset, array preloaded with line 3 = 0xA5…A5. Me read at addr 0xC0 ⇒ `Merd_valid_host`/`Metx_done_host` pulse LATENCY cycles later, `MeDataIn_host` = 0xA5…A5, Fe outputs stay 0.
- Write then read: Fe writes 0x1234…(512b) to addr 0x1040 (index 0x41), waits for `tx_done` only (no `rd_valid`). Me then reads 0x1040 ⇒ returns 0x1234….
- Contention: Fe and Me both assert read in the same cycle, repeatedly ⇒ grants go Me, Fe, Me, Fe. Each response is spaced LATENCY+2 cycles apart.
- Held op after done: requester keeps op = 01 for one extra cycle after its pulse ⇒ no second transaction starts (RECOVER absorbs it).
- Reset mid-write: assert `rst_n` = 0 two cycles after accepting a write to line 5 (old value 0) ⇒ all outputs 0 immediately, no `tx_done`, and a later read of line 5 returns 0.
- Reserved op: `Feop_host` = 11 held for 20 cycles ⇒ no response, and state stays IDLE.

Source files
------------

// File: rtl/mem_host_pkg.sv
// rtl/mem_host_pkg.sv - shared types and defaults for the host memory responder
package mem_host_pkg;

    localparam int LINE_BITS_DEF = 512;
    localparam int ADDR_BITS_DEF = 32;

    typedef enum logic [1:0] {
        OP_IDLE  = 2'b00,
        OP_READ  = 2'b01,
        OP_WRITE = 2'b10,
        OP_RSVD  = 2'b11
    } host_op_e;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_BUSY    = 2'b01,
        ST_RECOVER = 2'b10
    } resp_state_e;

    typedef enum logic {
        PORT_FE = 1'b0,
        PORT_ME = 1'b1
    } port_e;

    // Reserved op is deliberately excluded so it can never win arbitration.
    function automatic logic op_is_request(input logic [1:0] op);
        return (op == OP_READ) || (op == OP_WRITE);
    endfunction

endpackage

// File: rtl/mem_line_array.sv
// rtl/mem_line_array.sv - single-port line store, synchronous write, combinational read
module mem_line_array
    import mem_host_pkg::*;
#(
    parameter int LINE_BITS   = LINE_BITS_DEF,
    parameter int DEPTH_LINES = 256,
    localparam int IDX_BITS   = $clog2(DEPTH_LINES)
) (
    input  logic                 clk,
    input  logic                 i_we,
    input  logic [IDX_BITS-1:0]  i_addr,
    input  logic [LINE_BITS-1:0] i_wdata,
    output logic [LINE_BITS-1:0] o_rdata
);

    logic [LINE_BITS-1:0] r_mem [DEPTH_LINES];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_addr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_addr];

endmodule

// File: rtl/mem_host_responder.sv
// rtl/mem_host_responder.sv - fixed-latency line memory serving fetch and data host ports
module mem_host_responder
    import mem_host_pkg::*;
#(
    parameter int LINE_BITS   = LINE_BITS_DEF,
    parameter int ADDR_BITS   = ADDR_BITS_DEF,
    parameter int DEPTH_LINES = 256,
    parameter int LATENCY     = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [LINE_BITS-1:0] FeDataOut_host,
    input  logic [ADDR_BITS-1:0] FeAddrOut_host,
    input  logic [1:0]           Feop_host,
    output logic [LINE_BITS-1:0] FeDataIn_host,
    output logic                 Ferd_valid_host,
    output logic                 Fetx_done_host,
    input  logic [LINE_BITS-1:0] MeDataOut_host,
    input  logic [ADDR_BITS-1:0] MeAddrOut_host,
    input  logic [1:0]           Meop_host,
    output logic [LINE_BITS-1:0] MeDataIn_host,
    output logic                 Merd_valid_host,
    output logic                 Metx_done_host
);

    localparam int IDX_BITS = $clog2(DEPTH_LINES);
    localparam int CNT_BITS = $clog2(LATENCY + 1);

    resp_state_e          r_state;
    port_e                r_last_grant;
    port_e                r_port;
    host_op_e             r_op;
    logic [IDX_BITS-1:0]  r_idx;
    logic [LINE_BITS-1:0] r_wdata;
    logic [CNT_BITS-1:0]  r_cnt;

    logic                 w_fe_req;
    logic                 w_me_req;
    port_e                w_grant;
    logic                 w_resp;
    logic                 w_we;
    logic [LINE_BITS-1:0] w_rdata;
    logic                 w_unused_addr_bits;

    assign w_fe_req = op_is_request(Feop_host);
    assign w_me_req = op_is_request(Meop_host);

    // On a tie the port that was not granted last wins.
    assign w_grant = (w_me_req && (!w_fe_req || r_last_grant == PORT_FE)) ? PORT_ME : PORT_FE;

    assign w_resp = (r_state == ST_BUSY) && (r_cnt == '0);
    assign w_we   = w_resp && (r_op == OP_WRITE);

    assign w_unused_addr_bits = ^{FeAddrOut_host[5:0], FeAddrOut_host[ADDR_BITS-1:6+IDX_BITS],
                                  MeAddrOut_host[5:0], MeAddrOut_host[ADDR_BITS-1:6+IDX_BITS]};

    mem_line_array #(
        .LINE_BITS   (LINE_BITS),
        .DEPTH_LINES (DEPTH_LINES)
    ) u_array (
        .clk     (clk),
        .i_we    (w_we),
        .i_addr  (r_idx),
        .i_wdata (r_wdata),
        .o_rdata (w_rdata)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state         <= ST_IDLE;
            r_last_grant    <= PORT_FE;
            r_port          <= PORT_FE;
            r_op            <= OP_IDLE;
            r_idx           <= '0;
            r_wdata         <= '0;
            r_cnt           <= '0;
            FeDataIn_host   <= '0;
            Ferd_valid_host <= 1'b0;
            Fetx_done_host  <= 1'b0;
            MeDataIn_host   <= '0;
            Merd_valid_host <= 1'b0;
            Metx_done_host  <= 1'b0;
        end else begin
            Ferd_valid_host <= 1'b0;
            Fetx_done_host  <= 1'b0;
            Merd_valid_host <= 1'b0;
            Metx_done_host  <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_fe_req || w_me_req) begin
                        r_port       <= w_grant;
                        r_last_grant <= w_grant;
                        if (w_grant == PORT_ME) begin
                            r_op    <= host_op_e'(Meop_host);
                            r_idx   <= MeAddrOut_host[6 +: IDX_BITS];
                            r_wdata <= MeDataOut_host;
                        end else begin
                            r_op    <= host_op_e'(Feop_host);
                            r_idx   <= FeAddrOut_host[6 +: IDX_BITS];
                            r_wdata <= FeDataOut_host;
                        end
                        r_cnt   <= CNT_BITS'(LATENCY - 1);
                        r_state <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    if (w_resp) begin
                        if (r_port == PORT_ME) begin
                            Metx_done_host <= 1'b1;
                            if (r_op == OP_READ) begin
                                MeDataIn_host   <= w_rdata;
                                Merd_valid_host <= 1'b1;
                            end
                        end else begin
                            Fetx_done_host <= 1'b1;
                            if (r_op == OP_READ) begin
                                FeDataIn_host   <= w_rdata;
                                Ferd_valid_host <= 1'b1;
                            end
                        end
                        r_state <= ST_RECOVER;
                    end else begin
                        r_cnt <= r_cnt - CNT_BITS'(1);
                    end
                end
                // A requester may still hold its op here; skipping sampling prevents a reissue.
                ST_RECOVER: r_state <= ST_IDLE;
                default:    r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_host_responder.sv
// tb/tb_mem_host_responder.sv - directed scoreboard bench for mem_host_responder
module tb_mem_host_responder;

    localparam int LB  = 512;
    localparam int AB  = 32;
    localparam int DL  = 256;
    localparam int LAT = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [LB-1:0] fe_dout, me_dout, fe_din, me_din;
    logic [AB-1:0] fe_addr, me_addr;
    logic [1:0]    fe_op, me_op;
    logic          fe_rdv, fe_txd, me_rdv, me_txd;

    always #5 clk = ~clk;

    mem_host_responder #(
        .LINE_BITS   (LB),
        .ADDR_BITS   (AB),
        .DEPTH_LINES (DL),
        .LATENCY     (LAT)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .FeDataOut_host  (fe_dout),
        .FeAddrOut_host  (fe_addr),
        .Feop_host       (fe_op),
        .FeDataIn_host   (fe_din),
        .Ferd_valid_host (fe_rdv),
        .Fetx_done_host  (fe_txd),
        .MeDataOut_host  (me_dout),
        .MeAddrOut_host  (me_addr),
        .Meop_host       (me_op),
        .MeDataIn_host   (me_din),
        .Merd_valid_host (me_rdv),
        .Metx_done_host  (me_txd)
    );

    typedef struct {
        logic          port;
        logic          is_read;
        logic [LB-1:0] data;
    } exp_t;

    exp_t          sb_q[$];
    logic [LB-1:0] model [DL];
    logic [LB-1:0] cur_din [2];
    int            pulse_cycle[$];
    int            total = 0;
    int            bad = 0;
    int            cycle = 0;
    int            n_pulses = 0;

    always @(posedge clk) cycle++;

    task automatic chk(input string tag, input logic [LB-1:0] obs, input logic [LB-1:0] exp_v);
        total++;
        assert (obs === exp_v) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    // Response monitor: every pulse must match the head of the scoreboard.
    always @(negedge clk) begin
        exp_t       e;
        logic [3:0] exp_bits;
        if (rst_n && (fe_rdv || fe_txd || me_rdv || me_txd)) begin
            n_pulses++;
            pulse_cycle.push_back(cycle);
            chk("pulse_expected", LB'(sb_q.size() > 0), LB'(1));
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                exp_bits = e.port ? {2'b00, e.is_read, 1'b1} : {e.is_read, 1'b1, 2'b00};
                chk("pulse_bits", LB'({fe_rdv, fe_txd, me_rdv, me_txd}), LB'(exp_bits));
                if (e.is_read) cur_din[e.port] = e.data;
                chk(e.port ? "me_datain" : "fe_datain", e.port ? me_din : fe_din, cur_din[e.port]);
                chk(e.port ? "fe_datain_hold" : "me_datain_hold", e.port ? fe_din : me_din,
                    cur_din[!e.port]);
            end
        end
    end

    task automatic push_exp(input logic port, input logic is_read, input logic [AB-1:0] addr,
                            input logic [LB-1:0] data);
        exp_t e;
        int   idx;
        idx       = int'(addr[13:6]);
        e.port    = port;
        e.is_read = is_read;
        e.data    = is_read ? model[idx] : '0;
        if (!is_read) model[idx] = data;
        sb_q.push_back(e);
    endtask

    task automatic drive(input logic port, input logic [1:0] op, input logic [AB-1:0] addr,
                         input logic [LB-1:0] data);
        if (port) begin
            me_op = op; me_addr = addr; me_dout = data;
        end else begin
            fe_op = op; fe_addr = addr; fe_dout = data;
        end
    endtask

    // One transaction from an idle responder; checks accept-to-pulse latency.
    task automatic xact(input logic port, input logic is_read, input logic [AB-1:0] addr,
                        input logic [LB-1:0] data);
        int cyc;
        bit done;
        push_exp(port, is_read, addr, data);
        drive(port, is_read ? 2'b01 : 2'b10, addr, data);
        cyc = 0;
        done = 1'b0;
        while (!done && cyc < 50) begin
            @(posedge clk);
            cyc++;
            @(negedge clk);
            done = port ? me_txd : fe_txd;
        end
        chk("latency", LB'(cyc), LB'(LAT + 1));
        @(posedge clk);
        #1;
        drive(port, 2'b00, addr, data);
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [LB-1:0] pat;
        int            n0;
        int            wait_cyc;

        drive(1'b0, 2'b00, '0, '0);
        drive(1'b1, 2'b00, '0, '0);
        cur_din[0] = '0;
        cur_din[1] = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_datain", {fe_din ^ me_din} | fe_din, '0);
        chk("reset_pulses", LB'({fe_rdv, fe_txd, me_rdv, me_txd}), '0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Preload line 3 and line 5 through the fetch port.
        xact(1'b0, 1'b0, 32'h0000_00C0, {64{8'hA5}});
        xact(1'b0, 1'b0, 32'h0000_0140, '0);

        // Single read on the data port.
        xact(1'b1, 1'b1, 32'h0000_00C0, '0);

        // Write on fetch, then read back on data port.
        pat = {16{32'h1234_5678}};
        xact(1'b0, 1'b0, 32'h0000_1040, pat);
        xact(1'b1, 1'b1, 32'h0000_1040, '0);
        xact(1'b0, 1'b1, 32'h0000_00C0, '0);

        // Low and high address bits are ignored.
        pat = {8{64'hDEAD_BEEF_0BAD_F00D}};
        xact(1'b1, 1'b0, 32'hFFFF_0C80, pat);
        xact(1'b0, 1'b1, 32'h0000_0CBF, '0);

        // A held op across RECOVER must not start a second transaction.
        n0 = n_pulses;
        repeat (3 * LAT) @(posedge clk);
        #1;
        chk("no_reissue", LB'(n_pulses), LB'(n0));

        // Contention: both ports hold read, grants alternate Me, Fe, Me, Fe.
        push_exp(1'b1, 1'b1, 32'h0000_1040, '0);
        push_exp(1'b0, 1'b1, 32'h0000_00C0, '0);
        push_exp(1'b1, 1'b1, 32'h0000_1040, '0);
        push_exp(1'b0, 1'b1, 32'h0000_00C0, '0);
        n0 = n_pulses;
        drive(1'b0, 2'b01, 32'h0000_00C0, '0);
        drive(1'b1, 2'b01, 32'h0000_1040, '0);
        wait_cyc = 0;
        while (n_pulses < n0 + 4 && wait_cyc < 100) begin
            @(posedge clk);
            #1;
            wait_cyc++;
        end
        drive(1'b0, 2'b00, '0, '0);
        drive(1'b1, 2'b00, '0, '0);
        chk("contention_count", LB'(n_pulses - n0), LB'(4));
        for (int k = 1; k < 4; k++) begin
            if (pulse_cycle.size() >= 4)
                chk("contention_spacing",
                    LB'(pulse_cycle[pulse_cycle.size() - 4 + k] - pulse_cycle[pulse_cycle.size() - 5 + k]),
                    LB'(LAT + 2));
        end
        repeat (2) @(posedge clk);
        #1;

        // Reset two cycles after accepting a write to line 5 aborts it.
        drive(1'b0, 2'b10, 32'h0000_0140, {LB{1'b1}});
        @(posedge clk);
        @(posedge clk);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("abort_fe_datain", fe_din, '0);
        chk("abort_me_datain", me_din, '0);
        chk("abort_pulses", LB'({fe_rdv, fe_txd, me_rdv, me_txd}), '0);
        drive(1'b0, 2'b00, '0, '0);
        repeat (2) @(posedge clk);
        #1;
        cur_din[0] = '0;
        cur_din[1] = '0;
        rst_n = 1'b1;
        n0 = n_pulses;
        repeat (2 * LAT) @(posedge clk);
        #1;
        chk("abort_no_done", LB'(n_pulses), LB'(n0));
        xact(1'b1, 1'b1, 32'h0000_0140, '0);

        // Reserved op is never accepted, even against a real request.
        drive(1'b0, 2'b11, 32'h0000_00C0, {LB{1'b1}});
        n0 = n_pulses;
        repeat (20) @(posedge clk);
        #1;
        chk("rsvd_no_resp", LB'(n_pulses), LB'(n0));
        xact(1'b1, 1'b1, 32'h0000_00C0, '0);
        drive(1'b0, 2'b00, '0, '0);

        repeat (3 * LAT) @(posedge clk);
        #1;
        chk("scoreboard_empty", LB'(sb_q.size()), '0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
